// File: rtl/bingo_master_param.sv
// bingo_master_param: master-side bingo game controller for an N x N board.
// Runs board selection, mark tracking and line counting in one FSM. It also
// rejects duplicate calls and can auto-pick a number when a turn times out.
//
// Ports:
//   clk, rst (sync, active-low), interboard_rst (sync, active-high abort)
//   start_game, cur_number, enter_pulse      : local keypad side
//   inter_ready, interboard_en/_msg_type/_number : peer link (rx + tx accept)
//   transmit, ctrl_en, ctrl_msg_type, ctrl_number : peer link (tx request)
//   map, circle, line_count, game_state      : display / debug view
//   err_pulse, i_win                         : status
//
// Send handshake: ctrl_en is high for exactly the first cycle of every SEND_*
// state. ctrl_msg_type/ctrl_number become valid in that cycle and stay stable
// until the cycle in which inter_ready=1. The FSM leaves the SEND_* state on
// that edge. inter_ready may already be high in the ctrl_en cycle.
//
// Message type codes: STATE_TURN=1, SEL_NUM=2, STATE_WIN=3.
`ifndef STATE_TURN
`define STATE_TURN 3'd1
`endif
`ifndef SEL_NUM
`define SEL_NUM 3'd2
`endif
`ifndef STATE_WIN
`define STATE_WIN 3'd3
`endif

module bingo_master_param #(
  parameter int BOARD_N      = 5,
  parameter int NUM_W        = 5,
  parameter int WIN_LINES    = 5,
  parameter int TURN_TIMEOUT = 0,
  localparam int NN  = BOARD_N * BOARD_N,
  localparam int LCW = $clog2(2 * BOARD_N + 3)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  interboard_rst,
  input  logic                  start_game,
  input  logic [NUM_W-1:0]      cur_number,
  input  logic                  enter_pulse,
  input  logic                  inter_ready,
  input  logic                  interboard_en,
  input  logic [2:0]            interboard_msg_type,
  input  logic [NUM_W-1:0]      interboard_number,
  output logic                  transmit,
  output logic                  ctrl_en,
  output logic [2:0]            ctrl_msg_type,
  output logic [NUM_W-1:0]      ctrl_number,
  output logic [NUM_W*NN-1:0]   map,
  output logic [NN-1:0]         circle,
  output logic [LCW-1:0]        line_count,
  output logic [3:0]            game_state,
  output logic                  err_pulse,
  output logic                  i_win
);

  localparam int IW = $clog2(NN + 1);
  localparam int CW = 2 ** NUM_W;
  localparam int TW = (TURN_TIMEOUT > 1) ? $clog2(TURN_TIMEOUT) : 1;
  localparam bit TO_EN = (TURN_TIMEOUT > 0);
  localparam logic [TW-1:0]    TO_LAST = TW'((TURN_TIMEOUT > 0) ? TURN_TIMEOUT - 1 : 0);
  localparam logic [NUM_W-1:0] NN_V    = NUM_W'(NN);
  localparam logic [LCW-1:0]   WIN_V   = LCW'(WIN_LINES);
  localparam logic [IW-1:0]    IDX_LAST = IW'(NN - 1);

  localparam logic [3:0] S_IDLE          = 4'd0;
  localparam logic [3:0] S_SEND_START    = 4'd1;
  localparam logic [3:0] S_SEL           = 4'd2;
  localparam logic [3:0] S_SEND_SEL_DONE = 4'd3;
  localparam logic [3:0] S_WAIT_PEER_SEL = 4'd4;
  localparam logic [3:0] S_GUESS         = 4'd5;
  localparam logic [3:0] S_CHECK         = 4'd6;
  localparam logic [3:0] S_SEND_NUM      = 4'd7;
  localparam logic [3:0] S_SEND_WIN      = 4'd8;
  localparam logic [3:0] S_WAIT_PEER     = 4'd9;
  localparam logic [3:0] S_MARK_PEER     = 4'd10;
  localparam logic [3:0] S_FIN           = 4'd11;

  logic [3:0]          state_q, state_d;
  logic [NUM_W*NN-1:0] map_q, map_d;
  logic [NN-1:0]       circle_q, circle_d;
  logic [CW-1:0]       called_q, called_d;   // indexed by number, bit 0 unused
  logic [IW-1:0]       idx_q, idx_d;
  logic [NUM_W-1:0]    peer_q, peer_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic [LCW-1:0]      lc_q, lc_d;
  logic                win_q, win_d;
  logic                ctrl_en_q, ctrl_en_d;
  logic [2:0]          type_q, type_d;
  logic [NUM_W-1:0]    num_q, num_d;
  logic                err_q, err_d;

  logic [NUM_W-1:0]    low_num, lookup_num;
  logic                low_found, timeout_hit, cur_ok, peer_ok, guess_take;
  logic [NN-1:0]       hit_vec, count_src;
  logic [LCW-1:0]      lines;
  logic                row_full, col_full, diag_full, anti_full;

  function automatic logic num_ok(input logic [NUM_W-1:0] n);
    return (n != '0) && (n <= NN_V);
  endfunction

  // Lowest number not yet called; scanning downwards lets the smallest win.
  always_comb begin
    low_found = 1'b0;
    low_num   = '0;
    for (int n = NN; n >= 1; n--) begin
      if (!called_q[n]) begin
        low_found = 1'b1;
        low_num   = NUM_W'(n);
      end
    end
  end

  assign timeout_hit = TO_EN && (state_q == S_GUESS) && (timer_q == TO_LAST);
  assign cur_ok      = num_ok(cur_number) && !called_q[cur_number];
  assign peer_ok     = num_ok(interboard_number) && !called_q[interboard_number];
  // A keypad entry always decides the turn; auto-pick only fills silence.
  assign guess_take  = enter_pulse ? cur_ok : (timeout_hit && low_found);

  // One shared number->cell lookup, steered by the state that needs it.
  always_comb begin
    if (state_q == S_MARK_PEER)                  lookup_num = peer_q;
    else if (state_q == S_GUESS && !enter_pulse) lookup_num = low_num;
    else                                         lookup_num = cur_number;
  end

  always_comb begin
    hit_vec = '0;
    for (int i = 0; i < NN; i++)
      hit_vec[i] = (lookup_num != '0) && (map_q[i*NUM_W +: NUM_W] == lookup_num);
  end

  // MARK_PEER decides on the board including the cell it is marking now.
  assign count_src = (state_q == S_MARK_PEER) ? (circle_q | hit_vec) : circle_q;

  always_comb begin
    lines     = '0;
    row_full  = 1'b0;
    col_full  = 1'b0;
    diag_full = 1'b1;
    anti_full = 1'b1;
    for (int r = 0; r < BOARD_N; r++) begin
      row_full = 1'b1;
      col_full = 1'b1;
      for (int c = 0; c < BOARD_N; c++) begin
        row_full = row_full & count_src[r*BOARD_N + c];
        col_full = col_full & count_src[c*BOARD_N + r];
      end
      lines = lines + LCW'(row_full) + LCW'(col_full);
    end
    for (int i = 0; i < BOARD_N; i++) begin
      diag_full = diag_full & count_src[i*BOARD_N + i];
      anti_full = anti_full & count_src[i*BOARD_N + BOARD_N - 1 - i];
    end
    lines = lines + LCW'(diag_full) + LCW'(anti_full);
  end

  always_comb begin
    state_d   = state_q;
    map_d     = map_q;
    circle_d  = circle_q;
    called_d  = called_q;
    idx_d     = idx_q;
    peer_d    = peer_q;
    lc_d      = lc_q;
    win_d     = win_q;
    ctrl_en_d = 1'b0;
    type_d    = type_q;
    num_d     = num_q;
    err_d     = 1'b0;
    case (state_q)
      S_IDLE: if (start_game) begin
        state_d   = S_SEND_START;
        map_d     = '0;
        circle_d  = '0;
        called_d  = '0;
        idx_d     = '0;
        lc_d      = '0;
        win_d     = 1'b0;
        ctrl_en_d = 1'b1;
        type_d    = `STATE_TURN;
        num_d     = '0;
      end
      S_SEND_START: if (inter_ready) state_d = S_SEL;
      S_SEL: if (enter_pulse) begin
        // Unfilled cells hold 0, which is never legal, so the lookup
        // only matches numbers that are already placed.
        if (!num_ok(cur_number) || (|hit_vec)) begin
          err_d = 1'b1;
        end else begin
          map_d[int'(idx_q)*NUM_W +: NUM_W] = cur_number;
          idx_d = idx_q + IW'(1);
          if (idx_q == IDX_LAST) begin
            state_d   = S_SEND_SEL_DONE;
            ctrl_en_d = 1'b1;
            type_d    = `STATE_TURN;
            num_d     = '0;
          end
        end
      end
      S_SEND_SEL_DONE: if (inter_ready) state_d = S_WAIT_PEER_SEL;
      S_WAIT_PEER_SEL:
        if (interboard_en && interboard_msg_type == `STATE_TURN) state_d = S_GUESS;
      S_GUESS: begin
        if (guess_take) begin
          called_d[lookup_num] = 1'b1;
          circle_d = circle_q | hit_vec;
          num_d    = lookup_num;
          state_d  = S_CHECK;
        end else if (enter_pulse) begin
          err_d = 1'b1;
        end
      end
      S_CHECK: begin
        lc_d      = lines;
        ctrl_en_d = 1'b1;
        if (lines >= WIN_V) begin
          state_d = S_SEND_WIN;
          type_d  = `STATE_WIN;
          num_d   = '0;
        end else begin
          state_d = S_SEND_NUM;
          type_d  = `SEL_NUM;
        end
      end
      S_SEND_NUM: if (inter_ready) state_d = S_WAIT_PEER;
      S_SEND_WIN: if (inter_ready) begin
        state_d = S_FIN;
        win_d   = 1'b1;
      end
      S_WAIT_PEER: if (interboard_en) begin
        if (interboard_msg_type == `STATE_WIN) begin
          state_d = S_FIN;
          win_d   = 1'b0;
        end else if (interboard_msg_type == `SEL_NUM) begin
          if (peer_ok) begin
            peer_d  = interboard_number;
            state_d = S_MARK_PEER;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_MARK_PEER: begin
        called_d[peer_q] = 1'b1;
        circle_d = circle_q | hit_vec;
        lc_d     = lines;
        if (lines >= WIN_V) begin
          state_d   = S_SEND_WIN;
          ctrl_en_d = 1'b1;
          type_d    = `STATE_WIN;
          num_d     = '0;
        end else begin
          state_d = S_GUESS;
        end
      end
      S_FIN: if (start_game) begin
        state_d   = S_IDLE;
        win_d     = 1'b0;
        ctrl_en_d = 1'b1;
        type_d    = `STATE_TURN;
        num_d     = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The turn timer restarts on every entry to GUESS and parks at its last
  // value if nothing is left to auto-pick.
  always_comb begin
    timer_d = '0;
    if (state_q == S_GUESS && state_d == S_GUESS)
      timer_d = timeout_hit ? timer_q : timer_q + TW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst || interboard_rst) begin
      state_q   <= S_IDLE;
      map_q     <= '0;
      circle_q  <= '0;
      called_q  <= '0;
      idx_q     <= '0;
      peer_q    <= '0;
      timer_q   <= '0;
      lc_q      <= '0;
      win_q     <= 1'b0;
      ctrl_en_q <= 1'b0;
      type_q    <= '0;
      num_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      map_q     <= map_d;
      circle_q  <= circle_d;
      called_q  <= called_d;
      idx_q     <= idx_d;
      peer_q    <= peer_d;
      timer_q   <= timer_d;
      lc_q      <= lc_d;
      win_q     <= win_d;
      ctrl_en_q <= ctrl_en_d;
      type_q    <= type_d;
      num_q     <= num_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    case (state_q)
      S_WAIT_PEER_SEL, S_WAIT_PEER, S_MARK_PEER: transmit = 1'b0;
      default:                                   transmit = 1'b1;
    endcase
  end

  assign ctrl_en       = ctrl_en_q;
  assign ctrl_msg_type = type_q;
  assign ctrl_number   = num_q;
  assign map           = map_q;
  assign circle        = circle_q;
  assign line_count    = lc_q;
  assign game_state    = state_q;
  assign err_pulse     = err_q;
  assign i_win         = win_q;

endmodule

// File: tb/tb_bingo_master_param.sv
// Bench for bingo_master_param. dut5 is a 5x5 board that wins on one line
// and auto-picks after 8 cycles. dut4 is a 4x4 board that needs three lines
// and has no timeout. Sent messages and error pulses go to expected queues
// that a monitor drains.
module tb_bingo_master_param;

  localparam logic [2:0] T_TURN = 3'd1;
  localparam logic [2:0] T_SEL  = 3'd2;
  localparam logic [2:0] T_WIN  = 3'd3;

  logic       clk;
  logic [1:0] rst, ib_rst, start, enter_p, ready, ib_en;
  logic [4:0] cur_num [2];
  logic [4:0] ib_num  [2];
  logic [2:0] ib_type [2];

  logic         tx5, en5, err5, win5;
  logic [2:0]   type5;
  logic [4:0]   num5;
  logic [124:0] map5;
  logic [24:0]  circ5;
  logic [3:0]   lc5, gs5;

  logic         tx4, en4, err4, win4;
  logic [2:0]   type4;
  logic [4:0]   num4;
  logic [79:0]  map4;
  logic [15:0]  circ4;
  logic [3:0]   lc4, gs4;

  logic [7:0] exp_q0[$];
  logic [7:0] exp_q1[$];
  logic [3:0] err_q0[$];
  logic [3:0] err_q1[$];

  int tests = 0;
  int fails = 0;
  logic [124:0] exp_map5;

  bingo_master_param #(.BOARD_N(5), .NUM_W(5), .WIN_LINES(1), .TURN_TIMEOUT(8)) dut5 (
    .clk(clk), .rst(rst[0]), .interboard_rst(ib_rst[0]), .start_game(start[0]),
    .cur_number(cur_num[0]), .enter_pulse(enter_p[0]), .inter_ready(ready[0]),
    .interboard_en(ib_en[0]), .interboard_msg_type(ib_type[0]),
    .interboard_number(ib_num[0]), .transmit(tx5), .ctrl_en(en5),
    .ctrl_msg_type(type5), .ctrl_number(num5), .map(map5), .circle(circ5),
    .line_count(lc5), .game_state(gs5), .err_pulse(err5), .i_win(win5)
  );

  bingo_master_param #(.BOARD_N(4), .NUM_W(5), .WIN_LINES(3), .TURN_TIMEOUT(0)) dut4 (
    .clk(clk), .rst(rst[1]), .interboard_rst(ib_rst[1]), .start_game(start[1]),
    .cur_number(cur_num[1]), .enter_pulse(enter_p[1]), .inter_ready(ready[1]),
    .interboard_en(ib_en[1]), .interboard_msg_type(ib_type[1]),
    .interboard_number(ib_num[1]), .transmit(tx4), .ctrl_en(en4),
    .ctrl_msg_type(type4), .ctrl_number(num4), .map(map4), .circle(circ4),
    .line_count(lc4), .game_state(gs4), .err_pulse(err4), .i_win(win4)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_msg(input int d, input logic [2:0] t, input logic [4:0] n);
    if (d == 0) exp_q0.push_back({t, n});
    else        exp_q1.push_back({t, n});
  endtask

  task automatic push_err(input int d, input logic [3:0] st);
    if (d == 0) err_q0.push_back(st);
    else        err_q1.push_back(st);
  endtask

  task automatic enter(input int d, input logic [4:0] n);
    cur_num[d] = n;
    enter_p[d] = 1'b1;
    step();
    enter_p[d] = 1'b0;
  endtask

  task automatic accept(input int d);
    ready[d] = 1'b1;
    step();
    ready[d] = 1'b0;
  endtask

  task automatic start_pulse(input int d);
    start[d] = 1'b1;
    step();
    start[d] = 1'b0;
  endtask

  task automatic peer(input int d, input logic [2:0] t, input logic [4:0] n);
    ib_en[d]   = 1'b1;
    ib_type[d] = t;
    ib_num[d]  = n;
    step();
    ib_en[d]   = 1'b0;
  endtask

  task automatic fill(input int d, input int cnt);
    for (int n = 1; n <= cnt; n++) begin
      if (n == cnt) push_msg(d, T_TURN, 5'd0);
      enter(d, 5'(n));
    end
  endtask

  // own guess: enter -> CHECK -> SEND_NUM -> accepted -> WAIT_PEER
  task automatic my_guess(input int d, input logic [4:0] n);
    push_msg(d, T_SEL, n);
    enter(d, n);
    step();
    accept(d);
  endtask

  // peer call: WAIT_PEER -> MARK_PEER -> next state
  task automatic peer_mark(input int d, input logic [4:0] n);
    peer(d, T_SEL, n);
    step();
  endtask

  // scoreboard monitor
  task automatic monitor();
    logic [7:0] e;
    logic [3:0] s;
    forever begin
      @(negedge clk);
      if (en5) begin
        if (exp_q0.size() == 0) begin
          tests++; fails++;
          $display("FAIL msg5_unexpected: got %0h required none", {type5, num5});
        end else begin
          e = exp_q0.pop_front();
          check("msg5", 128'({type5, num5}), 128'(e));
        end
      end
      if (en4) begin
        if (exp_q1.size() == 0) begin
          tests++; fails++;
          $display("FAIL msg4_unexpected: got %0h required none", {type4, num4});
        end else begin
          e = exp_q1.pop_front();
          check("msg4", 128'({type4, num4}), 128'(e));
        end
      end
      if (err5) begin
        if (err_q0.size() == 0) begin
          tests++; fails++;
          $display("FAIL err5_unexpected: got state %0d required no error", gs5);
        end else begin
          s = err_q0.pop_front();
          check("err5_state", 128'(gs5), 128'(s));
        end
      end
      if (err4) begin
        if (err_q1.size() == 0) begin
          tests++; fails++;
          $display("FAIL err4_unexpected: got state %0d required no error", gs4);
        end else begin
          s = err_q1.pop_front();
          check("err4_state", 128'(gs4), 128'(s));
        end
      end
    end
  endtask

  initial begin
    rst = 2'b00; ib_rst = 2'b00; start = 2'b00; enter_p = 2'b00;
    ready = 2'b00; ib_en = 2'b00;
    for (int d = 0; d < 2; d++) begin
      cur_num[d] = '0; ib_num[d] = '0; ib_type[d] = '0;
    end
    fork monitor(); join_none
    repeat (3) step();
    check("rst_state5", 128'(gs5), 128'(0));
    check("rst_en5", 128'(en5), 128'(0));
    check("rst_map5", 128'(map5), 128'(0));
    check("rst_circle5", 128'(circ5), 128'(0));
    check("rst_lc5", 128'(lc5), 128'(0));
    check("rst_win5", 128'(win5), 128'(0));
    check("rst_state4", 128'(gs4), 128'(0));
    rst = 2'b11;
    step();

    // ---- dut5: selection ----
    push_msg(0, T_TURN, 5'd0);
    start_pulse(0);
    check("start5", 128'(gs5), 128'(1));
    accept(0);
    check("sel5", 128'(gs5), 128'(2));
    for (int n = 1; n <= 10; n++) enter(0, 5'(n));
    exp_map5 = '0;
    for (int i = 0; i < 10; i++) exp_map5[i*5 +: 5] = 5'(i + 1);
    push_err(0, 4'd2);
    enter(0, 5'd7);
    check("dup_map5", 128'(map5), 128'(exp_map5));
    push_err(0, 4'd2);
    enter(0, 5'd0);
    push_err(0, 4'd2);
    enter(0, 5'd26);
    check("bad_map5", 128'(map5), 128'(exp_map5));
    for (int n = 11; n <= 24; n++) enter(0, 5'(n));
    push_msg(0, T_TURN, 5'd0);
    enter(0, 5'd25);
    check("sel_done5", 128'(gs5), 128'(3));
    for (int i = 0; i < 25; i++) exp_map5[i*5 +: 5] = 5'(i + 1);
    check("full_map5", 128'(map5), 128'(exp_map5));
    accept(0);
    check("wait_sel5", 128'(gs5), 128'(4));
    check("tx_wait5", 128'(tx5), 128'(0));
    enter(0, 5'd9);
    peer(0, T_TURN, 5'd0);
    check("guess5", 128'(gs5), 128'(5));
    check("tx_guess5", 128'(tx5), 128'(1));

    // ---- dut5: guess 13, held send ----
    push_msg(0, T_SEL, 5'd13);
    enter(0, 5'd13);
    check("check5", 128'(gs5), 128'(6));
    check("circle13", 128'(circ5), 128'(25'h1000));
    step();
    check("send_num5", 128'(gs5), 128'(7));
    for (int k = 0; k < 3; k++) begin
      step();
      check("hold_en5", 128'(en5), 128'(0));
      check("hold_msg5", 128'({gs5, type5, num5}), 128'({4'd7, T_SEL, 5'd13}));
    end
    accept(0);
    check("wait_peer5", 128'(gs5), 128'(9));
    check("tx_wp5", 128'(tx5), 128'(0));
    enter(0, 5'd9);
    push_err(0, 4'd9);
    peer(0, T_SEL, 5'd13);
    check("peer_dup5", 128'(gs5), 128'(9));
    peer(0, T_SEL, 5'd1);
    check("mark5", 128'(gs5), 128'(10));
    step();
    check("back_guess5", 128'(gs5), 128'(5));
    push_err(0, 4'd5);
    enter(0, 5'd13);
    my_guess(0, 5'd2);
    peer_mark(0, 5'd3);

    // ---- dut5: timeout auto-pick of 4 ----
    push_msg(0, T_SEL, 5'd4);
    repeat (7) step();
    check("pre_timeout5", 128'(gs5), 128'(5));
    step();
    check("timeout5", 128'(gs5), 128'(6));
    step();
    accept(0);
    peer_mark(0, 5'd20);
    // enter on the timeout cycle beats the auto-pick of 5
    push_msg(0, T_SEL, 5'd9);
    repeat (7) step();
    enter(0, 5'd9);
    check("enter_wins5", 128'(gs5), 128'(6));
    step();
    accept(0);

    // ---- dut5: peer completes row 0 ----
    peer(0, T_SEL, 5'd5);
    check("mark_win5", 128'(gs5), 128'(10));
    push_msg(0, T_WIN, 5'd0);
    step();
    check("send_win5", 128'(gs5), 128'(8));
    check("lc_win5", 128'(lc5), 128'(1));
    check("circle_win5", 128'(circ5), 128'(25'h8111F));
    accept(0);
    check("fin5", 128'(gs5), 128'(11));
    check("i_win5", 128'(win5), 128'(1));
    push_msg(0, T_TURN, 5'd0);
    start_pulse(0);
    check("restart5", 128'(gs5), 128'(0));
    check("i_win_clr5", 128'(win5), 128'(0));

    // ---- dut5: reset during SEND_NUM ----
    push_msg(0, T_TURN, 5'd0);
    start_pulse(0);
    accept(0);
    fill(0, 25);
    accept(0);
    peer(0, T_TURN, 5'd0);
    push_msg(0, T_SEL, 5'd13);
    enter(0, 5'd13);
    step();
    check("g2_send5", 128'(gs5), 128'(7));
    rst[0] = 1'b0;
    step();
    rst[0] = 1'b1;
    check("mid_rst_state5", 128'(gs5), 128'(0));
    check("mid_rst_en5", 128'(en5), 128'(0));
    check("mid_rst_circle5", 128'(circ5), 128'(0));
    check("mid_rst_map5", 128'(map5), 128'(0));

    // ---- dut4: anti-diagonal + column 2 ----
    push_msg(1, T_TURN, 5'd0);
    start_pulse(1);
    accept(1);
    fill(1, 16);
    accept(1);
    peer(1, T_TURN, 5'd0);
    check("guess4", 128'(gs4), 128'(5));
    my_guess(1, 5'd4);
    peer_mark(1, 5'd7);
    my_guess(1, 5'd10);
    peer_mark(1, 5'd13);
    check("lc_anti4", 128'(lc4), 128'(1));
    check("guess_after4", 128'(gs4), 128'(5));
    my_guess(1, 5'd3);
    peer_mark(1, 5'd11);
    push_msg(1, T_SEL, 5'd15);
    enter(1, 5'd15);
    check("check4", 128'(gs4), 128'(6));
    step();
    check("send_num4", 128'(gs4), 128'(7));
    check("lc_two4", 128'(lc4), 128'(2));
    check("circle4", 128'(circ4), 128'(16'h564C));
    accept(1);
    peer(1, T_WIN, 5'd0);
    check("fin4", 128'(gs4), 128'(11));
    check("i_win4", 128'(win4), 128'(0));
    ib_rst[1] = 1'b1;
    step();
    ib_rst[1] = 1'b0;
    check("abort_state4", 128'(gs4), 128'(0));
    check("abort_map4", 128'(map4), 128'(0));
    check("abort_circle4", 128'(circ4), 128'(0));
    check("abort_lc4", 128'(lc4), 128'(0));

    repeat (3) step();
    check("msg_q0_left", 128'(exp_q0.size()), 128'(0));
    check("msg_q1_left", 128'(exp_q1.size()), 128'(0));
    check("err_q0_left", 128'(err_q0.size()), 128'(0));
    check("err_q1_left", 128'(err_q1.size()), 128'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
